// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multi-cycle RV32I control unit (FETCH/DECODE/EXEC/MEM/WB).
// The controller drives datapath selects, memory handshakes and a retired counter.
// Optional build macro RISCV_MC_MULDIV_EN: adds M-extension R-type ops (funct7=0000001)
// through a MULDIV wait state that is handshaked with md_start/md_done.
module riscv_mc_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             br_eq,
    input  logic             br_lt,
    input  logic             md_done,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic [2:0]       imm_sel,
    output logic             br_un,
    output logic             a_sel,
    output logic             b_sel,
    output logic [3:0]       alu_sel,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             md_start,
    output logic             trap,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5,
        S_MULDIV = 3'd6
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10, ALU_NOP = 4'd15;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;

    // Wait counter only needs to reach MEM_TIMEOUT-1; the timeout fires on that cycle.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

`ifdef RISCV_MC_MULDIV_EN
    localparam logic MD_LEGAL = 1'b1;
`else
    localparam logic MD_LEGAL = 1'b0;
`endif

    state_t            st, nxt;
    logic              run_q;     // high from the first edge that sees rst_n=1
    logic              active;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_hit;

    wire [6:0] opc = instr[6:0];
    wire [2:0] f3  = instr[14:12];
    wire [6:0] f7  = instr[31:25];

    // register fields are consumed by the datapath, not by the controller
    logic unused_instr;
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    wire is_r     = (opc == 7'b0110011);
    wire is_i     = (opc == 7'b0010011);
    wire is_ld    = (opc == 7'b0000011);
    wire is_st    = (opc == 7'b0100011);
    wire is_br    = (opc == 7'b1100011);
    wire is_jal   = (opc == 7'b1101111);
    wire is_jalr  = (opc == 7'b1100111);
    wire is_auipc = (opc == 7'b0010111);
    wire is_lui   = (opc == 7'b0110111);
    wire is_md    = is_r && (f7 == 7'b0000001) && MD_LEGAL;

    wire known  = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_auipc | is_lui;
    wire r_ok   = (f7 == 7'b0000000) ||
                  ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) || is_md;
    wire illegal = !known || (is_br && (f3[2:1] == 2'b01)) || (is_r && !r_ok);

    assign active   = rst_n && run_q;
    assign wait_hit = (MEM_TIMEOUT > 0) && (wait_cnt == WAIT_LAST);
    assign trap     = (st == S_TRAP);
    assign state    = st;

    // Branch condition: signed/unsigned comparison result comes from br_lt with br_un steering it
    logic taken;
    always_comb begin
        taken = 1'b0;
        case (f3)
            3'b000:         taken = br_eq;
            3'b001:         taken = !br_eq;
            3'b100, 3'b110: taken = br_lt;
            3'b101, 3'b111: taken = !br_lt;
            default:        taken = 1'b0;
        endcase
    end

    // Datapath selects decoded straight from the latched instruction
    always_comb begin
        imm_sel = IMM_I;
        a_sel   = 1'b0;
        b_sel   = 1'b1;
        alu_sel = ALU_ADD;
        wb_sel  = 2'd1;
        br_un   = is_br && (f3[2:1] == 2'b11);
        if (is_r || is_i) begin
            // I-type shifts carry funct7 in imm[11:5]; addi has no subtract form
            case (f3)
                3'b000:  alu_sel = (is_r && f7[5]) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_sel = ALU_SLL;
                3'b010:  alu_sel = ALU_SLT;
                3'b011:  alu_sel = ALU_SLTU;
                3'b100:  alu_sel = ALU_XOR;
                3'b101:  alu_sel = f7[5] ? ALU_SRA : ALU_SRL;
                3'b110:  alu_sel = ALU_OR;
                default: alu_sel = ALU_AND;
            endcase
            if (is_r) b_sel = 1'b0;
            if (is_md) begin
                alu_sel = ALU_NOP;
                wb_sel  = 2'd3;
            end
        end else if (is_ld) begin
            wb_sel = 2'd0;
        end else if (is_st) begin
            imm_sel = IMM_S;
        end else if (is_br) begin
            imm_sel = IMM_B;
            a_sel   = 1'b1;
        end else if (is_jal) begin
            imm_sel = IMM_J;
            a_sel   = 1'b1;
            wb_sel  = 2'd2;
        end else if (is_jalr) begin
            wb_sel = 2'd2;
        end else if (is_auipc) begin
            imm_sel = IMM_U;
            a_sel   = 1'b1;
        end else if (is_lui) begin
            imm_sel = IMM_U;
            alu_sel = ALU_PASSB;
        end else begin
            alu_sel = ALU_NOP;
        end
    end

    // Next state and strobes; everything is forced idle until the first post-reset edge
    always_comb begin
        nxt      = st;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        case (st)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we = 1'b1;
                    nxt   = S_DECODE;
                end else if (wait_hit) begin
                    nxt = S_TRAP;
                end
            end
            S_DECODE: nxt = illegal ? S_TRAP : S_EXEC;
            S_EXEC: begin
                if (is_br) begin
                    pc_we  = 1'b1;
                    pc_sel = taken;
                    nxt    = S_FETCH;
                end else if (is_ld || is_st) begin
                    nxt = S_MEM;
                end else if (is_md) begin
                    nxt = S_MULDIV;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_st;
                if (dmem_ready) begin
                    if (is_st) begin
                        pc_we = 1'b1;
                        nxt   = S_FETCH;
                    end else begin
                        nxt = S_WB;
                    end
                end else if (wait_hit) begin
                    nxt = S_TRAP;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                pc_sel = is_jal || is_jalr;
                nxt    = S_FETCH;
            end
            S_MULDIV: nxt = md_done ? S_WB : S_MULDIV;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_TRAP;
        endcase
        if (!active) begin
            nxt      = st;
            imem_req = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            pc_sel   = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            reg_we   = 1'b0;
        end
    end

    // State, retired counter and memory wait counter (cleared on every state change)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st       <= S_FETCH;
            run_q    <= 1'b0;
            retired  <= '0;
            wait_cnt <= '0;
        end else begin
            run_q <= 1'b1;
            st    <= nxt;
            if (pc_we) retired <= retired + 1'b1;
            if (nxt != st)
                wait_cnt <= '0;
            else if (active && (((st == S_FETCH) && !imem_ready) || ((st == S_MEM) && !dmem_ready)))
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

`ifdef RISCV_MC_MULDIV_EN
    logic md_pend;
    // md_start covers only the first MULDIV cycle
    always_ff @(posedge clk) begin
        if (!rst_n) md_pend <= 1'b0;
        else        md_pend <= active && (st == S_EXEC) && (nxt == S_MULDIV);
    end
    assign md_start = md_pend && active && (st == S_MULDIV);
`else
    assign md_start = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed bench for riscv_mc_ctrl (CNT_W=4 so the retired wrap is reachable, MEM_TIMEOUT=4).
module tb_riscv_mc_ctrl;
    localparam int CNT_W = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic imem_ready = 1'b1, dmem_ready = 1'b1, br_eq = 1'b0, br_lt = 1'b0, md_done = 1'b0;
    logic imem_req, ir_we, pc_we, pc_sel, br_un, a_sel, b_sel, dmem_req, dmem_we, reg_we, md_start, trap;
    logic [2:0] imm_sel, state;
    logic [3:0] alu_sel;
    logic [1:0] wb_sel;
    logic [CNT_W-1:0] retired;

    int checks = 0, errors = 0, exp_ret = 0;

    always #5 clk = ~clk;

    riscv_mc_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .br_eq(br_eq), .br_lt(br_lt), .md_done(md_done), .imem_req(imem_req), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .imm_sel(imm_sel), .br_un(br_un), .a_sel(a_sel), .b_sel(b_sel),
        .alu_sel(alu_sel), .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we), .wb_sel(wb_sel),
        .md_start(md_start), .trap(trap), .state(state), .retired(retired)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; md_done = 1'b0; br_eq = 1'b0; br_lt = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        tick;
        exp_ret = 0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; imem_ready = 1'b1; instr = 32'h002081B3;
        tick; tick;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
        checks++; if (retired !== 4'd0) begin errors++; $display("FAIL rst_retired got %0d exp 0", retired); end
        checks++; if ({trap, imem_req, ir_we, pc_we, reg_we, dmem_req, dmem_we} !== 7'b0) begin
            errors++; $display("FAIL rst_outputs got %b exp 0", {trap, imem_req, ir_we, pc_we, reg_we, dmem_req, dmem_we}); end
        rst_n = 1'b1; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_release_req got %b exp 0", imem_req); end
        tick;
        checks++; if ({imem_req, ir_we} !== 2'b11) begin errors++; $display("FAIL first_fetch got %b exp 11", {imem_req, ir_we}); end
        exp_ret = 0;
    endtask

    task automatic test_add;
        instr = 32'h002081B3;
        tick;
        checks++; if (state !== 3'd1 || {pc_we, reg_we, dmem_req, imem_req} !== 4'b0) begin
            errors++; $display("FAIL add_decode got st=%0d en=%b exp st=1 en=0000", state, {pc_we, reg_we, dmem_req, imem_req}); end
        tick;
        checks++; if (state !== 3'd2 || alu_sel !== 4'd0 || b_sel !== 1'b0 || reg_we !== 1'b0) begin
            errors++; $display("FAIL add_exec got st=%0d alu=%0d b=%b we=%b exp 2 0 0 0", state, alu_sel, b_sel, reg_we); end
        tick;
        checks++; if (state !== 3'd4 || reg_we !== 1'b1 || pc_we !== 1'b1 || pc_sel !== 1'b0 || wb_sel !== 2'd1 || retired !== 4'd0) begin
            errors++; $display("FAIL add_wb got st=%0d we=%b pcwe=%b pcsel=%b wb=%0d ret=%0d exp 4 1 1 0 1 0",
                               state, reg_we, pc_we, pc_sel, wb_sel, retired); end
        tick;
        exp_ret++;
        checks++; if (state !== 3'd0 || reg_we !== 1'b0 || retired !== 4'd1) begin
            errors++; $display("FAIL add_done got st=%0d we=%b ret=%0d exp 0 0 1", state, reg_we, retired); end
    endtask

    typedef struct {
        logic [31:0] ins;
        int imm, a, b, alu, wb, pcs;
    } row_t;

    task automatic test_decode_table;
        row_t tbl[10];
        tbl = '{
            '{32'h402081B3, -1, 0, 0,  1, 1, 0},   // sub
            '{32'h4020D1B3, -1, 0, 0,  7, 1, 0},   // sra
            '{32'h0020B1B3, -1, 0, 0,  4, 1, 0},   // sltu
            '{32'h4030D093,  0, 0, 1,  7, 1, 0},   // srai
            '{32'h0050C093,  0, 0, 1,  5, 1, 0},   // xori
            '{32'h000000B7,  4, -1, 1, 10, 1, 0},  // lui
            '{32'h00000097,  4, 1, 1,  0, 1, 0},   // auipc
            '{32'h000000EF,  3, 1, 1,  0, 2, 1},   // jal
            '{32'h000080E7,  0, 0, 1,  0, 2, 1},   // jalr
            '{32'h002081B3, -1, 0, 0,  0, 1, 0}    // add
        };
        for (int i = 0; i < 10; i++) begin
            instr = tbl[i].ins;
            tick; tick;
            checks++;
            if (state !== 3'd2 || alu_sel !== 4'(tbl[i].alu) || b_sel !== 1'(tbl[i].b) ||
                (tbl[i].imm >= 0 && imm_sel !== 3'(tbl[i].imm)) || (tbl[i].a >= 0 && a_sel !== 1'(tbl[i].a))) begin
                errors++; $display("FAIL dec_exec[%0d] got st=%0d alu=%0d b=%b imm=%0d a=%b exp 2 %0d %0d %0d %0d",
                                   i, state, alu_sel, b_sel, imm_sel, a_sel, tbl[i].alu, tbl[i].b, tbl[i].imm, tbl[i].a); end
            tick;
            checks++;
            if (state !== 3'd4 || wb_sel !== 2'(tbl[i].wb) || pc_sel !== 1'(tbl[i].pcs) || reg_we !== 1'b1) begin
                errors++; $display("FAIL dec_wb[%0d] got st=%0d wb=%0d pcsel=%b we=%b exp 4 %0d %0d 1",
                                   i, state, wb_sel, pc_sel, reg_we, tbl[i].wb, tbl[i].pcs); end
            tick;
            exp_ret++;
        end
        checks++; if (retired !== 4'(exp_ret)) begin errors++; $display("FAIL dec_retired got %0d exp %0d", retired, exp_ret % 16); end
    endtask

    task automatic test_load;
        instr = 32'h0000A283;   // lw x5,0(x1)
        tick; tick;
        checks++; if (b_sel !== 1'b1 || imm_sel !== 3'd0 || alu_sel !== 4'd0) begin
            errors++; $display("FAIL lw_exec got b=%b imm=%0d alu=%0d exp 1 0 0", b_sel, imm_sel, alu_sel); end
        dmem_ready = 1'b0;
        tick;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin dmem_ready = 1'b1; #1; end
            checks++; if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== 1'b0 || reg_we !== 1'b0 || pc_we !== 1'b0) begin
                errors++; $display("FAIL lw_mem[%0d] got st=%0d req=%b we=%b rwe=%b pcwe=%b exp 3 1 0 0 0",
                                   i, state, dmem_req, dmem_we, reg_we, pc_we); end
            tick;
        end
        checks++; if (state !== 3'd4 || wb_sel !== 2'd0 || reg_we !== 1'b1 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL lw_wb got st=%0d wb=%0d we=%b req=%b exp 4 0 1 0", state, wb_sel, reg_we, dmem_req); end
        tick;
        exp_ret++;
    endtask

    task automatic test_store;
        instr = 32'h0050A023;   // sw x5,0(x1)
        tick; tick;
        checks++; if (imm_sel !== 3'd1 || b_sel !== 1'b1) begin
            errors++; $display("FAIL sw_exec got imm=%0d b=%b exp 1 1", imm_sel, b_sel); end
        tick;
        checks++; if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== 1'b1 || pc_we !== 1'b1 || pc_sel !== 1'b0 || reg_we !== 1'b0) begin
            errors++; $display("FAIL sw_mem got st=%0d req=%b we=%b pcwe=%b pcsel=%b rwe=%b exp 3 1 1 1 0 0",
                               state, dmem_req, dmem_we, pc_we, pc_sel, reg_we); end
        tick;
        exp_ret++;
        checks++; if (state !== 3'd0 || retired !== 4'(exp_ret)) begin
            errors++; $display("FAIL sw_done got st=%0d ret=%0d exp 0 %0d", state, retired, exp_ret % 16); end
    endtask

    task automatic test_branch;
        instr = 32'h0020D063; br_lt = 1'b0;   // bge
        tick; tick;
        checks++; if (state !== 3'd2 || pc_we !== 1'b1 || pc_sel !== 1'b1 || br_un !== 1'b0 || imm_sel !== 3'd2 || a_sel !== 1'b1) begin
            errors++; $display("FAIL bge_taken got st=%0d pcwe=%b pcsel=%b un=%b imm=%0d a=%b exp 2 1 1 0 2 1",
                               state, pc_we, pc_sel, br_un, imm_sel, a_sel); end
        br_lt = 1'b1; #1;
        checks++; if (pc_we !== 1'b1 || pc_sel !== 1'b0) begin
            errors++; $display("FAIL bge_not_taken got pcwe=%b pcsel=%b exp 1 0", pc_we, pc_sel); end
        tick; exp_ret++;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL bge_return got %0d exp 0", state); end
        instr = 32'h0020F063; br_lt = 1'b0;   // bgeu
        tick; tick;
        checks++; if (br_un !== 1'b1 || pc_sel !== 1'b1) begin
            errors++; $display("FAIL bgeu got un=%b pcsel=%b exp 1 1", br_un, pc_sel); end
        tick; exp_ret++;
        instr = 32'h00209063; br_eq = 1'b1;   // bne, operands equal
        tick; tick;
        checks++; if (pc_sel !== 1'b0 || pc_we !== 1'b1) begin
            errors++; $display("FAIL bne_equal got pcsel=%b pcwe=%b exp 0 1", pc_sel, pc_we); end
        tick; exp_ret++;
        instr = 32'h00208063;                 // beq, operands equal
        tick; tick;
        checks++; if (pc_sel !== 1'b1) begin errors++; $display("FAIL beq_equal got pcsel=%b exp 1", pc_sel); end
        tick; exp_ret++;
        br_eq = 1'b0; br_lt = 1'b0;
        checks++; if (retired !== 4'(exp_ret)) begin errors++; $display("FAIL br_retired got %0d exp %0d", retired, exp_ret % 16); end
    endtask

    task automatic test_wrap;
        instr = 32'h00208063;
        for (int i = 0; i < 16; i++) begin
            tick; tick; tick;
            exp_ret++;
        end
        checks++; if (retired !== 4'(exp_ret)) begin errors++; $display("FAIL wrap_retired got %0d exp %0d", retired, exp_ret % 16); end
    endtask

    task automatic test_trap;
        instr = 32'h0000007F;
        tick;
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL trap_decode got %0d exp 1", state); end
        tick;
        for (int i = 0; i < 10; i++) begin
            checks++; if (state !== 3'd5 || trap !== 1'b1 || {imem_req, ir_we, pc_we, reg_we, dmem_req, dmem_we} !== 6'b0) begin
                errors++; $display("FAIL trap_hold[%0d] got st=%0d trap=%b en=%b exp 5 1 0", i, state, trap,
                                   {imem_req, ir_we, pc_we, reg_we, dmem_req, dmem_we}); end
            tick;
        end
        rst_n = 1'b0;
        tick;
        checks++; if (state !== 3'd0 || trap !== 1'b0 || retired !== 4'd0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL trap_reset got st=%0d trap=%b ret=%0d req=%b exp 0 0 0 0", state, trap, retired, imem_req); end
        rst_n = 1'b1;
        tick;
        exp_ret = 0;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL trap_refetch got %b exp 1", imem_req); end
    endtask

    task automatic test_illegal;
        logic [31:0] bad[3];
        bad = '{32'h0020A063, 32'h402091B3, 32'h00000000};   // branch f3=010, R f7=0100000/f3=001, opcode 0
        for (int i = 0; i < 3; i++) begin
            do_reset;
            instr = bad[i];
            tick; tick;
            checks++; if (state !== 3'd5 || trap !== 1'b1) begin
                errors++; $display("FAIL illegal[%0d] got st=%0d trap=%b exp 5 1", i, state, trap); end
        end
        do_reset;
    endtask

    task automatic test_timeout;
        do_reset;
        imem_ready = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (state !== 3'd0 || imem_req !== 1'b1 || ir_we !== 1'b0) begin
                errors++; $display("FAIL to_fetch[%0d] got st=%0d req=%b irwe=%b exp 0 1 0", i, state, imem_req, ir_we); end
            tick;
        end
        checks++; if (state !== 3'd5 || trap !== 1'b1) begin
            errors++; $display("FAIL to_trap got st=%0d trap=%b exp 5 1", state, trap); end
        do_reset;
        instr = 32'h0000A283; dmem_ready = 1'b0;
        tick; tick; tick;
        checks++; if (state !== 3'd3 || dmem_req !== 1'b1) begin
            errors++; $display("FAIL rstmem_pre got st=%0d req=%b exp 3 1", state, dmem_req); end
        rst_n = 1'b0; #1;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rstmem_low got %b exp 0", dmem_req); end
        tick;
        checks++; if (state !== 3'd0 || dmem_req !== 1'b0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL rstmem_after got st=%0d dreq=%b ireq=%b exp 0 0 0", state, dmem_req, imem_req); end
        do_reset;
    endtask

    task automatic test_muldiv;
        instr = 32'h022081B3;   // mul x3,x1,x2
        md_done = 1'b0;
        tick; tick;
`ifdef RISCV_MC_MULDIV_EN
        checks++; if (state !== 3'd2 || md_start !== 1'b0) begin
            errors++; $display("FAIL mul_exec got st=%0d start=%b exp 2 0", state, md_start); end
        tick;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin md_done = 1'b1; #1; end
            checks++; if (state !== 3'd6 || md_start !== (i == 0) || reg_we !== 1'b0) begin
                errors++; $display("FAIL mul_wait[%0d] got st=%0d start=%b we=%b exp 6 %0d 0", i, state, md_start, reg_we, i == 0); end
            tick;
        end
        md_done = 1'b0;
        checks++; if (state !== 3'd4 || wb_sel !== 2'd3 || reg_we !== 1'b1) begin
            errors++; $display("FAIL mul_wb got st=%0d wb=%0d we=%b exp 4 3 1", state, wb_sel, reg_we); end
        tick;
        exp_ret++;
`else
        checks++; if (state !== 3'd5 || trap !== 1'b1 || md_start !== 1'b0) begin
            errors++; $display("FAIL mul_trap got st=%0d trap=%b start=%b exp 5 1 0", state, trap, md_start); end
        do_reset;
`endif
    endtask

    initial begin
        test_reset;
        test_add;
        test_decode_table;
        test_load;
        test_store;
        test_branch;
        test_wrap;
        test_trap;
        test_illegal;
        test_timeout;
        test_muldiv;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/riscv_mc_ctrl.md
RISCV_MC_CTRL -- requirements
Module: riscv_mc_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of retired-instruction counter.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 0: max wait cycles on imem/dmem ready; 0 = no timeout.
REQ-003 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have inputs: instr  in  32  instruction register contents; imem_ready  in  1; dmem_ready  in  1; br_eq  in  1; br_lt  in  1; md_done  in  1  mul/div unit done.
REQ-005 SHALL have outputs: imem_req 1; ir_we 1; pc_we 1; pc_sel 1 (0=PC+4, 1=ALU); imm_sel 3 (I=0,S=1,B=2,J=3,U=4); br_un 1; a_sel 1 (0=reg,1=PC); b_sel 1 (0=reg,1=imm); alu_sel 4; dmem_req 1; dmem_we 1; reg_we 1; wb_sel 2 (0=mem,1=ALU,2=PC+4,3=muldiv); md_start 1; trap 1; state 3; retired CNT_W.
REQ-006 alu_sel codes SHALL be add 0, sub 1, sll 2, slt 3, sltu 4, xor 5, srl 6, sra 7, or 8, and 9, passB 10, nop 15.

Function
REQ-007 FSM states SHALL be FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 5, MULDIV 6; state output = encoding.
REQ-008 FETCH: imem_req=1; on imem_ready: ir_we=1 same cycle, next DECODE; else stay.
REQ-009 DECODE: opcode in {0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 1101111 jal, 1100111 jalr, 0010111 auipc, 0110111 lui} -> EXEC; any other opcode, branch funct3 010/011, or R funct7 not in {0000000, 0100000 (funct3 000/101 only)} -> TRAP.
REQ-010 EXEC: ALU/jal/jalr/auipc/lui -> WB; load/store -> MEM; branch -> FETCH with pc_we=1, pc_sel=taken.
REQ-011 Branch taken: beq br_eq; bne !br_eq; blt/bltu br_lt; bge/bgeu !br_lt; br_un=1 for bltu/bgeu only.
REQ-012 MEM: dmem_req=1, dmem_we=1 for store; on dmem_ready: load -> WB, store -> FETCH with pc_we=1, pc_sel=0.
REQ-013 WB: reg_we=1 and pc_we=1 for exactly one cycle; pc_sel=1 for jal/jalr else 0; next FETCH.
REQ-014 Datapath selects (imm_sel, a_sel, b_sel, alu_sel, wb_sel) SHALL be combinational from latched instr, valid in EXEC/MEM/WB/MULDIV; lui uses imm_sel=U, alu_sel=passB; I-ALU shifts decode funct7 as R-type.
REQ-015 reg_we, dmem_req, dmem_we, pc_we, ir_we SHALL be 0 in all states/cases not listed above.
REQ-016 retired SHALL increment by 1 on each cycle pc_we=1, wrapping modulo 2^CNT_W.
REQ-017 If MEM_TIMEOUT>0 and imem_ready/dmem_ready low for MEM_TIMEOUT consecutive cycles in FETCH/MEM, next state SHALL be TRAP; wait counter clears on each state entry.
REQ-018 TRAP: trap=1, all enables 0, state held until reset.

Reset
REQ-019 On clk edge with rst_n=0: state=FETCH, retired=0, wait counter=0, trap=0; all enables 0 the following cycle regardless of state mid-access.
REQ-020 Request outputs SHALL be 0 while rst_n=0; first imem_req asserted cycle after rst_n rises.

Configuration
REQ-021 Macro RISCV_MC_MULDIV_EN defined: R-type funct7=0000001 legal; EXEC -> MULDIV, md_start=1 on entry cycle only; wait md_done; -> WB with wb_sel=3.
REQ-022 RISCV_MC_MULDIV_EN undefined: funct7=0000001 -> TRAP in DECODE; md_start tied 0; MULDIV unreachable.

Verification
REQ-023 add x3,x1,x2 (0x002081B3), imem_ready=1 -> FETCH,DECODE,EXEC,WB; reg_we pulse cycle 4; retired 0->1.
REQ-024 lw, dmem_ready delayed 3 cycles -> MEM held 4 cycles with dmem_req=1, then WB wb_sel=0; sw -> dmem_we=1, no reg_we.
REQ-025 bge with br_lt=0 -> pc_we=1, pc_sel=1 in EXEC; br_lt=1 -> pc_sel=0; bgeu -> br_un=1.
REQ-026 opcode 0x7F -> TRAP after DECODE, trap=1 held 10 cycles; rst_n=0 one cycle -> FETCH, trap=0, retired=0.
REQ-027 MEM_TIMEOUT=4, imem_ready=0 -> TRAP after 4 FETCH cycles; reset asserted mid-MEM -> dmem_req=0 next cycle.
REQ-028 mul (funct7=0000001) with RISCV_MC_MULDIV_EN: md_start one cycle, md_done after 5 -> WB wb_sel=3; without macro -> TRAP.
